// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the parametrised sequence detector
//
// Purpose: FSM state encoding and the saturating fill-count helper used by
//          seq_detector_param.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, MATCH} state_e;

  // Wide enough to hold PAT_W up to 16.
  localparam int FILL_W = 5;

  // Count one more valid bit, never exceeding the pattern length.
  function automatic logic [FILL_W-1:0] next_fill(input logic [FILL_W-1:0] fill,
                                                  input logic [FILL_W-1:0] limit);
    return (fill >= limit) ? limit : fill + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky overflow flag
//
// Purpose: counts inc pulses up to all-ones; a pulse at the maximum is dropped
//          and raises ovf. clr empties the counter and ovf, but an inc on the
//          same edge still counts, leaving count = 1.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset
//   inc   in   count one event
//   clr   in   synchronous clear of count and ovf
//   count out  W-bit event count
//   ovf   out  sticky overflow flag
module sat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      // A match coinciding with the clear is kept rather than lost.
      count <= inc ? W'(1) : '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial bit-pattern detector with match counter
//
// Purpose: watches a serial stream for a run-time loadable PAT_W-bit pattern
//          (first received bit = MSB) and reports a Moore match flag plus a
//          saturating match count. OVERLAP selects whether a match suffix may
//          seed the next match.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   x           in   serial data bit
//   en          in   x valid this cycle; state holds when low
//   load        in   load pattern_in and restart detection
//   pattern_in  in   PAT_W-bit pattern
//   clr_count   in   synchronous clear of users_count and ovf
//   y           out  1 while in MATCH
//   users_count out  saturating match count
//   ovf         out  sticky: a match was dropped at counter maximum
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter int               CNT_W   = 10,
  parameter bit               OVERLAP = 1'b1,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             clr_count,
  output logic             y,
  output logic [CNT_W-1:0] users_count,
  output logic             ovf
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  state_e             state;
  state_e             state_nxt;
  logic [PAT_W-1:0]   hist;
  logic [PAT_W-1:0]   hist_shift;
  logic [PAT_W-1:0]   pat_r;
  logic [FILL_W-1:0]  fill;
  logic               take;
  logic               match;

  // load takes priority over the data bit in the same cycle.
  assign take       = en & ~load;
  assign hist_shift = {hist[PAT_W-2:0], x};
  // PAT_W-1 collected bits plus the incoming one complete a window.
  assign match      = take && (fill >= FILL_ARM) && (hist_shift == pat_r);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else if (en) begin
      unique case (state)
        IDLE:    state_nxt = COLLECT;
        COLLECT: state_nxt = match ? MATCH : COLLECT;
        MATCH:   state_nxt = (match && OVERLAP) ? MATCH : COLLECT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    y = (state == MATCH);
  end

  // Pattern register, bit history and fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r <= PAT_RST;
      hist  <= '0;
      fill  <= '0;
    end else if (load) begin
      pat_r <= pattern_in;
      hist  <= '0;
      fill  <= '0;
    end else if (en) begin
      if (match && !OVERLAP) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_shift;
        fill <= next_fill(fill, FILL_MAX);
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .clr  (clr_count),
    .count(users_count),
    .ovf  (ovf)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       clr_count = 1'b0;
  logic [2:0] p3 = 3'b010;
  logic [4:0] p5 = 5'b10110;

  logic       y_ov, y_no, y_sat, y_w5o, y_w5n;
  logic       f_ov, f_no, f_sat, f_w5o, f_w5n;
  logic [9:0] c_ov, c_no, c_w5o, c_w5n;
  logic [2:0] c_sat;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .CNT_W(10), .OVERLAP(1'b1), .PAT_RST(3'b010)) u_ov (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(p3),
    .clr_count(clr_count), .y(y_ov), .users_count(c_ov), .ovf(f_ov));
  seq_detector_param #(.PAT_W(3), .CNT_W(10), .OVERLAP(1'b0), .PAT_RST(3'b010)) u_no (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(p3),
    .clr_count(clr_count), .y(y_no), .users_count(c_no), .ovf(f_no));
  seq_detector_param #(.PAT_W(3), .CNT_W(3), .OVERLAP(1'b1), .PAT_RST(3'b010)) u_sat (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(p3),
    .clr_count(clr_count), .y(y_sat), .users_count(c_sat), .ovf(f_sat));
  seq_detector_param #(.PAT_W(5), .CNT_W(10), .OVERLAP(1'b1), .PAT_RST(5'b10110)) u_w5o (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(p5),
    .clr_count(clr_count), .y(y_w5o), .users_count(c_w5o), .ovf(f_w5o));
  seq_detector_param #(.PAT_W(5), .CNT_W(10), .OVERLAP(1'b0), .PAT_RST(5'b10110)) u_w5n (
    .clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pattern_in(p5),
    .clr_count(clr_count), .y(y_w5n), .users_count(c_w5n), .ovf(f_w5n));

  typedef struct packed {
    logic [4:0]      y;
    logic [4:0]      ovf;
    logic [4:0][9:0] cnt;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int   pw[5]   = '{3, 3, 3, 5, 5};
  bit   ovl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int   cmax[5] = '{1023, 1023, 7, 1023, 1023};

  logic [15:0] m_hist[5];
  logic [15:0] m_pat[5];
  int          m_n[5];
  logic        m_y[5];
  int          m_cnt[5];
  logic        m_ovf[5];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = '0;
      m_pat[i]  = (i < 3) ? 16'h0002 : 16'h0016;
      m_n[i]    = 0;
      m_y[i]    = 1'b0;
      m_cnt[i]  = 0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  // Reference: bits received since the last restart, matched on their trailing window.
  task automatic model_step(input logic xi, input logic ei, input logic li, input logic ci);
    logic        mt;
    logic [15:0] nh;
    logic [15:0] mask;
    for (int i = 0; i < 5; i++) begin
      mt = 1'b0;
      if (li) begin
        m_pat[i]  = (i < 3) ? {13'b0, p3} : {11'b0, p5};
        m_hist[i] = '0;
        m_n[i]    = 0;
        m_y[i]    = 1'b0;
      end else if (ei) begin
        nh   = {m_hist[i][14:0], xi};
        mask = 16'((1 << pw[i]) - 1);
        mt   = (m_n[i] + 1 >= pw[i]) && ((nh & mask) == m_pat[i]);
        m_y[i] = mt;
        if (mt && !ovl[i]) begin
          m_hist[i] = '0;
          m_n[i]    = 0;
        end else begin
          m_hist[i] = nh;
          m_n[i]    = m_n[i] + 1;
        end
      end
      if (ci) begin
        m_cnt[i] = mt ? 1 : 0;
        m_ovf[i] = 1'b0;
      end else if (mt) begin
        if (m_cnt[i] == cmax[i]) m_ovf[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic obs_t model_snap();
    obs_t s;
    for (int i = 0; i < 5; i++) begin
      s.y[i]   = m_y[i];
      s.ovf[i] = m_ovf[i];
      s.cnt[i] = 10'(m_cnt[i]);
    end
    return s;
  endfunction

  function automatic obs_t dut_snap();
    obs_t d;
    d.y      = {y_w5n, y_w5o, y_sat, y_no, y_ov};
    d.ovf    = {f_w5n, f_w5o, f_sat, f_no, f_ov};
    d.cnt[0] = c_ov;
    d.cnt[1] = c_no;
    d.cnt[2] = {7'b0, c_sat};
    d.cnt[3] = c_w5o;
    d.cnt[4] = c_w5n;
    return d;
  endfunction

  task automatic compare_pop();
    obs_t e;
    obs_t d;
    d = dut_snap();
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
        check($sformatf("y[%0d]", i), 32'(d.y[i]), 32'(e.y[i]));
        check($sformatf("ovf[%0d]", i), 32'(d.ovf[i]), 32'(e.ovf[i]));
        check($sformatf("cnt[%0d]", i), 32'(d.cnt[i]), 32'(e.cnt[i]));
      end
    end
  endtask

  task automatic cyc(input logic xi, input logic ei, input logic li, input logic ci);
    @(negedge clk);
    x = xi; en = ei; load = li; clr_count = ci;
    model_step(xi, ei, li, ci);
    sb_q.push_back(model_snap());
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", 32'({y_ov, y_no, y_sat, y_w5o, y_w5n}), 32'd0);
    check("rst_ovf", 32'({f_ov, f_no, f_sat, f_w5o, f_w5n}), 32'd0);
    check("rst_cnt", 32'(c_ov | c_no | c_w5o | c_w5n | {7'b0, c_sat}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Overlap versus non-overlap on 0,1,0,1,0 then 0,1,0
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("ov_y3", 32'(y_ov), 32'd1);
    check("no_y3", 32'(y_no), 32'd1);
    cyc(1, 1, 0, 0);
    check("ov_y4", 32'(y_ov), 32'd0);
    cyc(0, 1, 0, 0);
    check("ov_y5", 32'(y_ov), 32'd1);
    check("no_y5", 32'(y_no), 32'd0);
    check("ov_cnt5", 32'(c_ov), 32'd2);
    check("no_cnt5", 32'(c_no), 32'd1);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("no_cnt8", 32'(c_no), 32'd2);
    check("ov_cnt8", 32'(c_ov), 32'd3);

    // Clear with en low: MATCH and y are held
    cyc(0, 0, 0, 1);
    check("clr_cnt", 32'(c_ov), 32'd0);
    check("hold_y", 32'(y_ov), 32'd1);

    // Saturation of the 3-bit counter
    cyc(0, 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      if (k == 7) begin
        check("sat7_cnt", 32'(c_sat), 32'd7);
        check("sat7_ovf", 32'(f_sat), 32'd0);
      end
      if (k == 8) begin
        check("sat8_cnt", 32'(c_sat), 32'd7);
        check("sat8_ovf", 32'(f_sat), 32'd1);
      end
    end
    check("sat9_cnt", 32'(c_sat), 32'd7);
    check("sat9_ovf", 32'(f_sat), 32'd1);
    check("ov_cnt9", 32'(c_ov), 32'd9);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 1);
    check("clrm_cnt", 32'(c_sat), 32'd1);
    check("clrm_ovf", 32'(f_sat), 32'd0);
    check("clrm_ov", 32'(c_ov), 32'd1);

    // Reload 010 with data ignored, gap inside a partial match
    p3 = 3'b010;
    cyc(1, 1, 1, 0);
    check("load_y", 32'(y_ov), 32'd0);
    check("load_cnt", 32'(c_ov), 32'd1);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int g = 0; g < 5; g++) begin
      cyc(1'($urandom_range(0, 1)), 0, 0, 0);
      check("gap_y0", 32'(y_ov), 32'd0);
    end
    cyc(0, 1, 0, 0);
    check("gap_match", 32'(y_ov), 32'd1);
    check("gap_cnt", 32'(c_ov), 32'd2);
    for (int g = 0; g < 3; g++) begin
      cyc(1'($urandom_range(0, 1)), 0, 0, 0);
      check("gap_y1", 32'(y_ov), 32'd1);
    end

    // New pattern 110
    p3 = 3'b110;
    cyc(0, 1, 1, 0);
    check("ld110_y", 32'(y_ov), 32'd0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("p110_y", 32'(y_ov), 32'd1);
    check("p110_cnt", 32'(c_ov), 32'd3);

    // Asynchronous reset between edges discards a partial match
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("arst_y", 32'(y_ov), 32'd0);
    check("arst_cnt", 32'(c_ov), 32'd0);
    model_reset();
    #1 rst = 1'b1;
    cyc(0, 1, 0, 0);
    check("arst_b1", 32'(y_ov), 32'd0);
    cyc(1, 1, 0, 0);
    check("arst_b2", 32'(y_ov), 32'd0);
    cyc(0, 1, 0, 0);
    check("arst_b3", 32'(y_ov), 32'd1);
    check("arst_cnt3", 32'(c_ov), 32'd1);

    // load and clr_count on the same edge
    p3 = 3'b010;
    cyc(0, 1, 1, 1);
    check("ldclr_cnt", 32'(c_ov), 32'd0);
    check("ldclr_y", 32'(y_ov), 32'd0);

    // Random stream against the reference model
    for (int n = 0; n < 20000; n++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
